l80_spi_port: RTL and testbench



---
 rtl/l80_spi_port_pkg.sv | 24 ++
 rtl/l80_spi_port_if.sv | 12 +
 rtl/l80_spi_port_spi_engine.sv | 94 +++++++++
 rtl/l80_spi_port.sv | 101 ++++++++++
 tb/tb_l80_spi_port.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/l80_spi_port_pkg.sv
// Shared definitions for the light8080 SPI master: IO addresses, register bit
// positions and the engine state encoding.
package l80_spi_port_pkg;

    localparam logic [7:0] SPI_DATA_ADDR = 8'h90;
    localparam logic [7:0] SPI_STAT_ADDR = 8'h91;
    localparam logic [7:0] SPI_CTRL_ADDR = 8'h92;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_OVR_BIT  = 1;
    localparam int STAT_FULL_BIT = 4;

    localparam int CTRL_MAN_BIT  = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int CTRL_IE_BIT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } spi_state_t;

endpackage

// File: rtl/l80_spi_port_if.sv
// CPU IO bus as seen by an IO-space peripheral of the light8080 SOC.
interface l80_spi_port_if;
    logic       io_sel;
    logic       io_rd;
    logic       io_wr;
    logic [7:0] io_addr;
    logic [7:0] io_din;
    logic [7:0] io_dout;

    modport master (output io_sel, io_rd, io_wr, io_addr, io_din, input io_dout);
    modport slave  (input io_sel, io_rd, io_wr, io_addr, io_din, output io_dout);
endinterface

// File: rtl/l80_spi_port_spi_engine.sv
// SPI mode 0 shift engine: divider, bit sequencing, shift register and sck/mosi.
//
// state    | meaning
// ST_IDLE  | no transfer, sck low, waiting for start
// ST_SETUP | first half period, mosi already presents bit 7
// ST_HIGH  | sck high, miso sampled on entry
// ST_LOW   | sck low, shift on entry; after the 8th one the transfer completes
module spi_engine
    import l80_spi_port_pkg::*;
(
    input  logic       slow_clock2,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [3:0] div,
    input  logic       miso,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi
);

    spi_state_t state, state_nxt;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       samp;
    logic       reload;

    always_ff @(posedge slow_clock2 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        reload    = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) begin state_nxt = ST_SETUP; reload = 1'b1; end
            ST_SETUP: if (cnt == 4'd0) begin state_nxt = ST_HIGH; reload = 1'b1; end
            ST_HIGH:  if (cnt == 4'd0) begin state_nxt = ST_LOW; reload = 1'b1; end
            ST_LOW: begin
                if (cnt == 4'd0) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_IDLE;
                        done      = 1'b1;
                    end else begin
                        state_nxt = ST_HIGH;
                        reload    = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // div is read only at reload so a CTRL change mid-transfer never tears a half period
    always_ff @(posedge slow_clock2 or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            samp    <= 1'b0;
            sck     <= 1'b0;
        end else begin
            if (reload)            cnt <= div;
            else if (cnt != 4'd0)  cnt <= cnt - 4'd1;

            if (state == ST_IDLE && start) begin
                shreg   <= tx_byte;
                bit_idx <= 3'd0;
            end

            if (state_nxt == ST_HIGH && state != ST_HIGH) begin
                sck  <= 1'b1;
                samp <= miso;
            end

            if (state_nxt == ST_LOW && state != ST_LOW) begin
                sck   <= 1'b0;
                shreg <= {shreg[6:0], samp};
            end

            if (state == ST_LOW && state_nxt == ST_HIGH) bit_idx <= bit_idx + 3'd1;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign mosi    = busy ? shreg[7] : 1'b0;
    assign rx_byte = shreg;

endmodule

// File: rtl/l80_spi_port.sv
// light8080 IO-space SPI master: DATA/STATUS/CTRL register file, flags, read mux
// and interrupt, wrapped around the shift engine.
module l80_spi_port
    import l80_spi_port_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = SPI_DATA_ADDR,
    parameter logic [3:0] DIV_RST   = 4'd3
) (
    input  logic          slow_clock2,
    input  logic          reset,
    l80_spi_port_if.slave bus,
    output logic          sck,
    output logic          mosi,
    input  logic          miso,
    output logic          ss_n,
    output logic          irq
);

    logic [3:0] ctrl_div;
    logic       ctrl_ie, ctrl_auto, ctrl_man;
    logic [7:0] rx_data, rd_mux;
    logic       rx_full, ovr;
    logic       busy, done;
    logic [7:0] rx_byte;
    logic       hit_data, hit_stat, hit_ctrl;
    logic       wr_data, rd_data, rd_stat, wr_ctrl, rd_any;

    assign hit_data = bus.io_sel && (bus.io_addr == BASE_ADDR);
    assign hit_stat = bus.io_sel && (bus.io_addr == BASE_ADDR + 8'd1);
    assign hit_ctrl = bus.io_sel && (bus.io_addr == BASE_ADDR + 8'd2);
    assign wr_data  = hit_data && bus.io_wr;
    assign rd_data  = hit_data && bus.io_rd;
    assign rd_stat  = hit_stat && bus.io_rd;
    assign wr_ctrl  = hit_ctrl && bus.io_wr;
    assign rd_any   = bus.io_sel && bus.io_rd;

    spi_engine u_engine (
        .slow_clock2 (slow_clock2),
        .reset       (reset),
        .start       (wr_data && !busy),
        .tx_byte     (bus.io_din),
        .div         (ctrl_div),
        .miso        (miso),
        .busy        (busy),
        .done        (done),
        .rx_byte     (rx_byte),
        .sck         (sck),
        .mosi        (mosi)
    );

    always_comb begin
        rd_mux = 8'h00;
        if (hit_data) begin
            rd_mux = rx_data;
        end else if (hit_stat) begin
            rd_mux[STAT_BUSY_BIT] = busy;
            rd_mux[STAT_OVR_BIT]  = ovr;
            rd_mux[STAT_FULL_BIT] = rx_full;
        end else if (hit_ctrl) begin
            rd_mux[7:4]           = ctrl_div;
            rd_mux[CTRL_IE_BIT]   = ctrl_ie;
            rd_mux[CTRL_AUTO_BIT] = ctrl_auto;
            rd_mux[CTRL_MAN_BIT]  = ctrl_man;
        end
    end

    // completion beats a same-cycle DATA read: the new byte stays flagged, no overrun
    always_ff @(posedge slow_clock2 or posedge reset) begin
        if (reset) begin
            ctrl_div    <= DIV_RST;
            ctrl_ie     <= 1'b0;
            ctrl_auto   <= 1'b1;
            ctrl_man    <= 1'b1;
            rx_data     <= 8'h00;
            rx_full     <= 1'b0;
            ovr         <= 1'b0;
            bus.io_dout <= 8'h00;
        end else begin
            if (wr_ctrl) begin
                ctrl_div  <= bus.io_din[7:4];
                ctrl_ie   <= bus.io_din[CTRL_IE_BIT];
                ctrl_auto <= bus.io_din[CTRL_AUTO_BIT];
                ctrl_man  <= bus.io_din[CTRL_MAN_BIT];
            end

            if (done) rx_data <= rx_byte;

            if (done)         rx_full <= 1'b1;
            else if (rd_data) rx_full <= 1'b0;

            if ((done && rx_full && !rd_data) || (wr_data && busy)) ovr <= 1'b1;
            else if (rd_stat)                                       ovr <= 1'b0;

            if (rd_any) bus.io_dout <= rd_mux;
        end
    end

    assign ss_n = ctrl_auto ? !busy : ctrl_man;
    assign irq  = rx_full && ctrl_ie;

endmodule

// File: tb/tb_l80_spi_port.sv
// Directed self-checking bench for the light8080 SPI master peripheral.
module tb_l80_spi_port;

    logic slow_clock2 = 1'b0;
    logic reset = 1'b1;
    logic sck, mosi, ss_n, irq, miso;
    logic loop_en = 1'b0;
    logic miso_drv = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    l80_spi_port_if bus ();

    assign miso = loop_en ? mosi : miso_drv;

    l80_spi_port #(.BASE_ADDR(8'h90), .DIV_RST(4'd3)) dut (
        .slow_clock2 (slow_clock2),
        .reset       (reset),
        .bus         (bus.slave),
        .sck         (sck),
        .mosi        (mosi),
        .miso        (miso),
        .ss_n        (ss_n),
        .irq         (irq)
    );

    always #5 slow_clock2 = ~slow_clock2;

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge slow_clock2);
        bus.io_sel = 1'b1; bus.io_wr = 1'b1; bus.io_addr = addr; bus.io_din = data;
        @(posedge slow_clock2); #1;
        bus.io_sel = 1'b0; bus.io_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        @(negedge slow_clock2);
        bus.io_sel = 1'b1; bus.io_rd = 1'b1; bus.io_addr = addr;
        @(posedge slow_clock2); #1;
        data = bus.io_dout;
        bus.io_sel = 1'b0; bus.io_rd = 1'b0;
    endtask

    // counts edges after the launching write until ss_n returns high; -1 on timeout
    task automatic wait_ss_high(input int budget, output int cycles);
        cycles = 0;
        while (ss_n !== 1'b1 && cycles < budget) begin
            @(posedge slow_clock2); #1;
            cycles++;
        end
        if (ss_n !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        bus.io_sel = 1'b0; bus.io_rd = 1'b0; bus.io_wr = 1'b0;
        bus.io_addr = 8'h00; bus.io_din = 8'h00;
        #22;
        n_checks++;
        if (sck !== 1'b0 || ss_n !== 1'b1 || irq !== 1'b0 || mosi !== 1'b0 || bus.io_dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pins: sck=%b ss_n=%b irq=%b mosi=%b dout=%h want 0 1 0 0 00",
                     sck, ss_n, irq, mosi, bus.io_dout);
        end
        @(negedge slow_clock2); reset = 1'b0;
        bus_read(8'h92, d);
        n_checks++;
        if (d !== 8'h33) begin n_fail++; $display("FAIL reset_ctrl: got %h want 33", d); end
        bus_read(8'h91, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", d); end
        bus_read(8'h55, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h want 00", d); end
    endtask

    task automatic test_loopback_div0();
        logic [7:0] d, bits;
        int cyc, rises;
        logic prev_sck;
        loop_en = 1'b1;
        bus_write(8'h92, 8'h02);
        bus_write(8'h90, 8'hA5);
        n_checks++;
        if (ss_n !== 1'b0 || mosi !== 1'b1) begin
            n_fail++; $display("FAIL start_pins: ss_n=%b mosi=%b want 0 1", ss_n, mosi);
        end
        cyc = 0; rises = 0; bits = 8'h00; prev_sck = sck;
        while (ss_n !== 1'b1 && cyc < 100) begin
            @(posedge slow_clock2); #1;
            cyc++;
            if (sck === 1'b1 && prev_sck === 1'b0 && rises < 8) begin
                bits = {bits[6:0], mosi};
                rises++;
            end
            prev_sck = sck;
        end
        n_checks++;
        if (cyc !== 17) begin n_fail++; $display("FAIL busy_len_div0: got %0d want 17", cyc); end
        n_checks++;
        if (bits !== 8'hA5 || rises !== 8) begin
            n_fail++; $display("FAIL mosi_bits: got %h (%0d rises) want a5 (8 rises)", bits, rises);
        end
        bus_read(8'h91, d);
        n_checks++;
        if (d !== 8'h10) begin n_fail++; $display("FAIL status_full: got %h want 10", d); end
        bus_read(8'h90, d);
        n_checks++;
        if (d !== 8'hA5) begin n_fail++; $display("FAIL rx_a5: got %h want a5", d); end
        bus_read(8'h91, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL full_cleared: got %h want 00", d); end
        loop_en = 1'b0;
    endtask

    task automatic test_div3_irq();
        logic [7:0] d;
        int cyc, first_rise, second_rise;
        logic prev_sck;
        miso_drv = 1'b1;
        bus_write(8'h92, 8'h36);
        bus_write(8'h90, 8'h00);
        cyc = 0; first_rise = -1; second_rise = -1; prev_sck = sck;
        while (irq !== 1'b1 && cyc < 200) begin
            @(posedge slow_clock2); #1;
            cyc++;
            if (sck === 1'b1 && prev_sck === 1'b0) begin
                if (first_rise < 0) first_rise = cyc;
                else if (second_rise < 0) second_rise = cyc;
            end
            prev_sck = sck;
        end
        n_checks++;
        if (first_rise !== 4) begin n_fail++; $display("FAIL first_rise_div3: got %0d want 4", first_rise); end
        n_checks++;
        if (second_rise - first_rise !== 8) begin
            n_fail++; $display("FAIL sck_period_div3: got %0d want 8", second_rise - first_rise);
        end
        n_checks++;
        if (cyc !== 68) begin n_fail++; $display("FAIL irq_time_div3: got %0d want 68", cyc); end
        bus_read(8'h90, d);
        n_checks++;
        if (d !== 8'hFF) begin n_fail++; $display("FAIL rx_ff: got %h want ff", d); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
        miso_drv = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int cyc;
        loop_en = 1'b1;
        bus_write(8'h92, 8'h02);
        bus_write(8'h90, 8'h11);
        bus_write(8'h90, 8'h22);
        bus_read(8'h91, d);
        n_checks++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL status_ovr_busy: got %h want 03", d); end
        bus_read(8'h91, d);
        n_checks++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL ovr_cleared: got %h want 01", d); end
        wait_ss_high(100, cyc);
        n_checks++;
        if (cyc < 0) begin n_fail++; $display("FAIL b2b_timeout: got %0d want >=0", cyc); end
        bus_read(8'h90, d);
        n_checks++;
        if (d !== 8'h11) begin n_fail++; $display("FAIL b2b_first_kept: got %h want 11", d); end
        loop_en = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        int cyc;
        loop_en = 1'b1;
        bus_write(8'h90, 8'h3C);
        wait_ss_high(100, cyc);
        bus_read(8'h91, d);
        n_checks++;
        if (d !== 8'h10) begin n_fail++; $display("FAIL ovr_first: got %h want 10", d); end
        bus_write(8'h90, 8'hC3);
        wait_ss_high(100, cyc);
        n_checks++;
        if (cyc !== 17) begin n_fail++; $display("FAIL ovr_len: got %0d want 17", cyc); end
        bus_read(8'h91, d);
        n_checks++;
        if (d !== 8'h12) begin n_fail++; $display("FAIL ovr_status: got %h want 12", d); end
        bus_read(8'h90, d);
        n_checks++;
        if (d !== 8'hC3) begin n_fail++; $display("FAIL ovr_data: got %h want c3", d); end
        bus_read(8'h91, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL ovr_after: got %h want 00", d); end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int cyc;
        loop_en = 1'b1;
        bus_write(8'h92, 8'h02);
        bus_write(8'h90, 8'h5A);
        repeat (9) @(posedge slow_clock2);
        @(negedge slow_clock2);
        reset = 1'b1;
        #1;
        n_checks++;
        if (sck !== 1'b0 || ss_n !== 1'b1 || mosi !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_pins: sck=%b ss_n=%b mosi=%b want 0 1 0", sck, ss_n, mosi);
        end
        @(negedge slow_clock2);
        reset = 1'b0;
        bus_read(8'h91, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL mid_reset_status: got %h want 00", d); end
        bus_write(8'h90, 8'h5A);
        wait_ss_high(200, cyc);
        n_checks++;
        if (cyc !== 68) begin n_fail++; $display("FAIL post_reset_len: got %0d want 68", cyc); end
        bus_read(8'h90, d);
        n_checks++;
        if (d !== 8'h5A) begin n_fail++; $display("FAIL post_reset_data: got %h want 5a", d); end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loopback_div0();
        test_div3_irq();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
